// File: rtl/random_variable_selector.sv
// Picks one set bit of the latched integer/boolean presence masks uniformly at random (count, LFSR rejection draw, select).
// Latency: 1 + N + draw + select + 1 cycles from start to done; empty mask takes 1 + N + 1.
// No backpressure: in_start is honoured only in IDLE and dropped otherwise; results hold until the next done.
module random_variable_selector #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_start,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] in_integer_variables,
    input  logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] in_boolean_variables,
    output logic out_busy,
    output logic out_done,
    output logic out_valid,
    output logic out_is_boolean,
    output logic [((MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX > MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX) ?
                   MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX : MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_variable_index
);
    localparam int IW   = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
    localparam int BW   = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam int NI   = 2**IW;
    localparam int NB   = 2**BW;
    localparam int N    = NI + NB;
    localparam int CW   = $clog2(N + 1);
    localparam int PW   = $clog2(N);
    localparam int IDXW = (IW > BW) ? IW : BW;

    localparam logic [LFSR_WIDTH-1:0] SEED = (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;
    // x^16+x^14+x^13+x^11+1 at 16 bits; other widths fall back to x^n+x^(n-1)+1
    localparam logic [LFSR_WIDTH-1:0] TAPS = (LFSR_WIDTH == 16) ? LFSR_WIDTH'(16'hB400)
                                                                : (LFSR_WIDTH'(3) << (LFSR_WIDTH - 2));
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        DRAW   = 3'd2,
        SELECT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [LFSR_WIDTH-1:0] lfsr;
    logic [N-1:0]          mask;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         t;
    logic [PW-1:0]         idx;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cand;
    logic          sel_bool;
    logic [PW-1:0] sel_off;

    assign cnt_inc  = cnt + CW'(mask[idx]);
    assign cand     = lfsr[CW-1:0];
    assign sel_bool = (idx >= PW'(NI));
    assign sel_off  = sel_bool ? (idx - PW'(NI)) : idx;

    assign out_busy = (state != IDLE);
    assign out_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_start) state_next = COUNT;
            COUNT:   if (idx == LAST) state_next = (cnt_inc == '0) ? DONE : DRAW;
            DRAW:    if (cand < cnt) state_next = SELECT;
            SELECT:  if (mask[idx] && (t == '0)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr               <= SEED;
            mask               <= '0;
            cnt                <= '0;
            t                  <= '0;
            idx                <= '0;
            out_valid          <= 1'b0;
            out_is_boolean     <= 1'b0;
            out_variable_index <= '0;
        end else begin
            lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)};
            case (state)
                IDLE: begin
                    if (in_start) begin
                        mask <= {in_boolean_variables, in_integer_variables};
                        cnt  <= '0;
                        idx  <= '0;
                    end
                end
                COUNT: begin
                    cnt <= cnt_inc;
                    idx <= idx + PW'(1);
                    if ((idx == LAST) && (cnt_inc == '0)) begin
                        out_valid          <= 1'b0;
                        out_is_boolean     <= 1'b0;
                        out_variable_index <= '0;
                    end
                end
                DRAW: begin
                    if (cand < cnt) begin
                        t   <= cand;
                        idx <= '0;
                    end
                end
                SELECT: begin
                    // t counts down the set bits still to skip before the chosen one
                    if (mask[idx] && (t == '0)) begin
                        out_valid          <= 1'b1;
                        out_is_boolean     <= sel_bool;
                        out_variable_index <= IDXW'(sel_off);
                    end else begin
                        if (mask[idx]) t <= t - CW'(1);
                        idx <= idx + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_random_variable_selector.sv
// Directed bench for random_variable_selector: reset, empty/single masks, uniformity, start-while-busy, mid-select reset.
module tb_random_variable_selector;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_start;
    logic [1:0] in_integer_variables;
    logic [1:0] in_boolean_variables;
    logic       out_busy;
    logic       out_done;
    logic       out_valid;
    logic       out_is_boolean;
    logic [0:0] out_variable_index;

    int checks = 0;
    int errors = 0;

    random_variable_selector dut (
        .clk                  (clk),
        .reset                (reset),
        .in_start             (in_start),
        .in_integer_variables (in_integer_variables),
        .in_boolean_variables (in_boolean_variables),
        .out_busy             (out_busy),
        .out_done             (out_done),
        .out_valid            (out_valid),
        .out_is_boolean       (out_is_boolean),
        .out_variable_index   (out_variable_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start, clears the masks afterwards, and returns at the negedge where out_done is seen.
    task automatic run(input logic [1:0] im, input logic [1:0] bm, output int lat, output bit got);
        @(negedge clk);
        in_integer_variables = im;
        in_boolean_variables = bm;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_integer_variables = 2'b00;
        in_boolean_variables = 2'b00;
        lat = 2;
        while (!out_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        got = out_done;
    endtask

    initial begin
        int  lat;
        bit  got;
        int  hist [4];
        int  ndone;
        logic [2:0] res;

        reset = 1'b1;
        in_start = 1'b0;
        in_integer_variables = 2'b00;
        in_boolean_variables = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_busy",  32'(out_busy), 0);
        chk("rst_done",  32'(out_done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_isb",   32'(out_is_boolean), 0);
        chk("rst_idx",   32'(out_variable_index), 0);
        chk("rst_lfsr",  32'(dut.lfsr), 32'hACE1);

        // empty mask
        run(2'b00, 2'b00, lat, got);
        chk("empty_got",   32'(got), 1);
        chk("empty_lat",   32'(lat), 6);
        chk("empty_valid", 32'(out_valid), 0);
        chk("empty_isb",   32'(out_is_boolean), 0);
        chk("empty_idx",   32'(out_variable_index), 0);
        @(negedge clk);
        chk("empty_one_pulse", 32'(out_done), 0);

        // single integer slot 1
        for (int i = 0; i < 50; i++) begin
            run(2'b10, 2'b00, lat, got);
            chk("int1_got", 32'(got), 1);
            chk("int1_res", 32'({out_valid, out_is_boolean, out_variable_index}), 32'b101);
        end

        // single boolean slot 0
        for (int i = 0; i < 50; i++) begin
            run(2'b00, 2'b01, lat, got);
            chk("bool0_got", 32'(got), 1);
            chk("bool0_res", 32'({out_valid, out_is_boolean, out_variable_index}), 32'b110);
        end

        // two set bits (int0, bool1): never an unset slot
        for (int i = 0; i < 40; i++) begin
            run(2'b01, 2'b10, lat, got);
            res = {out_valid, out_is_boolean, out_variable_index};
            chk("pair_got", 32'(got), 1);
            chk("pair_member", 32'((res == 3'b100) || (res == 3'b111)), 1);
        end

        // uniformity over all four slots
        for (int k = 0; k < 4; k++) hist[k] = 0;
        for (int i = 0; i < 4000; i++) begin
            run(2'b11, 2'b11, lat, got);
            chk("uni_got", 32'(got), 1);
            chk("uni_valid", 32'(out_valid), 1);
            chk("uni_lat_min", 32'(lat >= 8), 1);
            hist[{out_is_boolean, out_variable_index}]++;
            if (i % 3 == 1) @(negedge clk);
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("uni_bin%0d", k), 32'((hist[k] >= 850) && (hist[k] <= 1150)), 1);

        // start while busy: second pulse two cycles later with other masks
        @(negedge clk);
        in_integer_variables = 2'b01;
        in_boolean_variables = 2'b00;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_integer_variables = 2'b00;
        @(negedge clk);
        in_boolean_variables = 2'b10;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_boolean_variables = 2'b00;
        ndone = 0;
        res = 3'b000;
        for (int c = 0; c < 60; c++) begin
            if (out_done) begin
                ndone++;
                res = {out_valid, out_is_boolean, out_variable_index};
            end
            @(negedge clk);
        end
        chk("busy_ndone", 32'(ndone), 1);
        chk("busy_res", 32'(res), 32'b100);

        // start during the done cycle is dropped
        run(2'b10, 2'b00, lat, got);
        chk("dstart_got", 32'(got), 1);
        in_integer_variables = 2'b11;
        in_boolean_variables = 2'b11;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_integer_variables = 2'b00;
        in_boolean_variables = 2'b00;
        chk("dstart_busy", 32'(out_busy), 0);
        @(negedge clk);
        chk("dstart_busy2", 32'(out_busy), 0);

        // reset in the middle of SELECT
        in_integer_variables = 2'b11;
        in_boolean_variables = 2'b11;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_integer_variables = 2'b00;
        in_boolean_variables = 2'b00;
        lat = 0;
        while (dut.state != 3'd3 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_in_select", 32'(dut.state == 3'd3), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy",  32'(out_busy), 0);
        chk("mid_done",  32'(out_done), 0);
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_isb",   32'(out_is_boolean), 0);
        chk("mid_idx",   32'(out_variable_index), 0);
        chk("mid_lfsr",  32'(dut.lfsr), 32'hACE1);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_done) ndone++;
            @(negedge clk);
        end
        chk("mid_no_done", 32'(ndone), 0);
        run(2'b00, 2'b10, lat, got);
        chk("post_got", 32'(got), 1);
        chk("post_res", 32'({out_valid, out_is_boolean, out_variable_index}), 32'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
